// File: rtl/prio_enc_pkg.sv
// Shared constants, state encoding and width helper for the pipelined priority encoder.
package prio_enc_pkg;

    localparam int PRIO_FIXED = 0;
    localparam int PRIO_RR    = 1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Index width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/prio_enc_pipe_find_first.sv
// Combinational first-set-bit search starting at a given pointer, wrapping N-1 -> 0.
module prio_find_first
    import prio_enc_pkg::*;
#(
    parameter int N = 4,
    parameter int W = clog2_min1(N)
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] start,
    output logic [W-1:0] idx,
    output logic         hit,
    output logic [N-1:0] onehot
);

    int pos;

    always_comb begin
        idx    = '0;
        hit    = 1'b0;
        onehot = '0;
        pos    = 0;
        for (int k = 0; k < N; k++) begin
            pos = (int'(start) + k) % N;
            if (!hit && vec[W'(pos)]) begin
                hit              = 1'b1;
                idx              = W'(pos);
                onehot[W'(pos)]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prio_enc_pipe.sv
// Registered N-to-log2(N) priority encoder with valid/ready on both sides.
// Optional out_multi ambiguity flag enabled by PRIO_ENC_MULTIHOT_ERR_EN.
//
// state | meaning
// EMPTY | no result held
// FULL  | result held in output register
module prio_enc_pipe
    import prio_enc_pkg::*;
#(
    parameter int N       = 4,
    parameter int W       = clog2_min1(N),
    parameter int RR_MODE = PRIO_FIXED
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_req,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic         out_hit,
`ifdef PRIO_ENC_MULTIHOT_ERR_EN
    output logic         out_multi,
`endif
    output logic [N-1:0] out_onehot
);

    localparam logic ST_EMPTY = EMPTY;
    localparam logic ST_FULL  = FULL;

    logic         state;
    logic [W-1:0] rr_ptr;
    logic [W-1:0] ptr_next;
    logic [W-1:0] start;
    logic [W-1:0] sel_idx;
    logic         sel_hit;
    logic [N-1:0] sel_onehot;
    logic         accept;
    logic         fire;

    assign out_valid = (state == ST_FULL);
    assign in_ready  = (state == ST_EMPTY) || out_ready;
    assign accept    = in_valid && in_ready;
    assign fire      = out_valid && out_ready;

    // The pointer advances on a completed hit handoff; a same-cycle accept sees the new value.
    always_comb begin
        ptr_next = rr_ptr;
        if (fire && out_hit)
            ptr_next = (out_idx == W'(N - 1)) ? '0 : out_idx + W'(1);
    end

    assign start = (RR_MODE == PRIO_RR) ? ptr_next : '0;

    prio_find_first #(.N(N), .W(W)) u_find (
        .vec    (in_req),
        .start  (start),
        .idx    (sel_idx),
        .hit    (sel_hit),
        .onehot (sel_onehot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_EMPTY;
            rr_ptr     <= '0;
            out_idx    <= '0;
            out_hit    <= 1'b0;
            out_onehot <= '0;
        end else begin
            rr_ptr <= ptr_next;
            if (accept) begin
                state      <= ST_FULL;
                out_idx    <= sel_idx;
                out_hit    <= sel_hit;
                out_onehot <= sel_onehot;
            end else if (fire) begin
                state <= ST_EMPTY;
            end
        end
    end

`ifdef PRIO_ENC_MULTIHOT_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            out_multi <= 1'b0;
        else if (accept)
            out_multi <= |(in_req & (in_req - N'(1)));
    end
`endif

endmodule

// File: tb/tb_prio_enc_pipe.sv
// Scoreboard bench: three encoder instances (N=4 fixed, N=4 round-robin, N=6 round-robin).
module tb_prio_enc_pipe;

    typedef struct packed {
        logic [2:0] idx;
        logic       hit;
        logic [5:0] onehot;
        logic       multi;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [5:0] in_req6;
    logic       out_ready;

    logic       rdy_a, rdy_b, rdy_c;
    logic       val_a, val_b, val_c;
    logic [1:0] idx_a, idx_b;
    logic [2:0] idx_c;
    logic       hit_a, hit_b, hit_c;
    logic [3:0] oh_a, oh_b;
    logic [5:0] oh_c;
`ifdef PRIO_ENC_MULTIHOT_ERR_EN
    logic       mul_a, mul_b, mul_c;
`endif

    int compared   = 0;
    int mismatched = 0;

    exp_t qa[$], qb[$], qc[$];
    int   ptr_b = 0, ptr_c = 0;
    logic exp_valid  = 1'b0;
    logic prev_stall = 1'b0;
    logic [29:0] prev_out;

    always #5 clk = ~clk;

    prio_enc_pipe #(.N(4), .RR_MODE(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_a), .in_req(in_req6[3:0]),
        .out_valid(val_a), .out_ready(out_ready), .out_idx(idx_a), .out_hit(hit_a),
`ifdef PRIO_ENC_MULTIHOT_ERR_EN
        .out_multi(mul_a),
`endif
        .out_onehot(oh_a));

    prio_enc_pipe #(.N(4), .RR_MODE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_b), .in_req(in_req6[3:0]),
        .out_valid(val_b), .out_ready(out_ready), .out_idx(idx_b), .out_hit(hit_b),
`ifdef PRIO_ENC_MULTIHOT_ERR_EN
        .out_multi(mul_b),
`endif
        .out_onehot(oh_b));

    prio_enc_pipe #(.N(6), .RR_MODE(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_c), .in_req(in_req6),
        .out_valid(val_c), .out_ready(out_ready), .out_idx(idx_c), .out_hit(hit_c),
`ifdef PRIO_ENC_MULTIHOT_ERR_EN
        .out_multi(mul_c),
`endif
        .out_onehot(oh_c));

    function automatic void chk(input string nm, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference: among the set lines, take the lowest one at or above start, else the lowest overall.
    function automatic exp_t ref_sel(input int n, input logic [5:0] req, input int start);
        exp_t e;
        int   hits[$];
        int   sel;
        logic [5:0] one;
        e = '0;
        for (int i = 0; i < n; i++)
            if (req[i]) hits.push_back(i);
        if (hits.size() == 0) return e;
        sel = hits[0];
        for (int j = hits.size() - 1; j >= 0; j--)
            if (hits[j] >= start) sel = hits[j];
        one      = 6'd1;
        e.hit    = 1'b1;
        e.idx    = 3'(sel);
        e.onehot = one << sel;
        e.multi  = (hits.size() >= 2);
        return e;
    endfunction

    task automatic cycle(input logic v, input logic [5:0] req, input logic ordy);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid  = v;
        in_req6   = req;
        out_ready = ordy;
        @(negedge clk);
        if (in_valid && (!exp_valid || out_ready)) begin
            e = ref_sel(4, in_req6 & 6'h0f, 0);
            qa.push_back(e);
            e = ref_sel(4, in_req6 & 6'h0f, ptr_b);
            qb.push_back(e);
            if (e.hit) ptr_b = (int'(e.idx) + 1) % 4;
            e = ref_sel(6, in_req6, ptr_c);
            qc.push_back(e);
            if (e.hit) ptr_c = (int'(e.idx) + 1) % 6;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_valid_a", int'(val_a), 0);
        chk("rst_valid_b", int'(val_b), 0);
        chk("rst_valid_c", int'(val_c), 0);
        qa.delete(); qb.delete(); qc.delete();
        ptr_b = 0; ptr_c = 0;
        in_valid = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic cmp_out(input string nm, input exp_t e, input int idx, input int hit, input int oh);
        chk({nm, "_idx"}, idx, int'(e.idx));
        chk({nm, "_hit"}, hit, int'(e.hit));
        chk({nm, "_onehot"}, oh, int'(e.onehot));
    endtask

    // Monitor: handshake timing, result popping and hold-under-stall checks.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            exp_valid  <= 1'b0;
            prev_stall <= 1'b0;
        end else begin
            chk("valid_a", int'(val_a), int'(exp_valid));
            chk("valid_b", int'(val_b), int'(exp_valid));
            chk("valid_c", int'(val_c), int'(exp_valid));
            chk("in_ready_a", int'(rdy_a), int'(!exp_valid || out_ready));
            chk("in_ready_c", int'(rdy_c), int'(!exp_valid || out_ready));
            if (prev_stall)
                chk("hold", int'(prev_out != {idx_a, hit_a, oh_a, idx_b, hit_b, oh_b, idx_c, hit_c, oh_c}), 0);
            if (val_c) chk("idx_c_range", int'(idx_c <= 3'd5), 1);
            if (exp_valid && out_ready) begin
                if (qa.size() == 0 || qb.size() == 0 || qc.size() == 0) begin
                    chk("queue_underflow", 1, 0);
                end else begin
                    e = qa.pop_front();
                    cmp_out("a", e, int'(idx_a), int'(hit_a), int'(oh_a));
`ifdef PRIO_ENC_MULTIHOT_ERR_EN
                    chk("a_multi", int'(mul_a), int'(e.multi));
`endif
                    e = qb.pop_front();
                    cmp_out("b", e, int'(idx_b), int'(hit_b), int'(oh_b));
`ifdef PRIO_ENC_MULTIHOT_ERR_EN
                    chk("b_multi", int'(mul_b), int'(e.multi));
`endif
                    e = qc.pop_front();
                    cmp_out("c", e, int'(idx_c), int'(hit_c), int'(oh_c));
`ifdef PRIO_ENC_MULTIHOT_ERR_EN
                    chk("c_multi", int'(mul_c), int'(e.multi));
`endif
                end
            end
            exp_valid  <= (in_valid && (!exp_valid || out_ready)) || (exp_valid && !out_ready);
            prev_stall <= exp_valid && !out_ready;
            prev_out   <= {idx_a, hit_a, oh_a, idx_b, hit_b, oh_b, idx_c, hit_c, oh_c};
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_req6   = '0;
        out_ready = 1'b0;
        #12;
        chk("reset_valid", int'(val_a), 0);
        chk("reset_idx", int'(idx_a), 0);
        chk("reset_hit", int'(hit_a), 0);
        chk("reset_onehot", int'(oh_c), 0);
        chk("reset_in_ready", int'(rdy_b), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // one-hot inputs back-to-back
        cycle(1, 6'b000001, 1);
        cycle(1, 6'b000010, 1);
        cycle(1, 6'b000100, 1);
        cycle(1, 6'b001000, 1);
        // multi-hot and no-hit
        cycle(1, 6'b001110, 1);
        cycle(1, 6'b000000, 1);
        cycle(0, 6'b000000, 1);

        // round-robin wrap, then 1001 with pointer at 1
        do_reset();
        repeat (5) cycle(1, 6'b001111, 1);
        cycle(1, 6'b001001, 1);
        cycle(0, 6'b000000, 1);

        // back-pressure: held input must appear exactly once after release
        cycle(1, 6'b000011, 1);
        repeat (3) cycle(1, 6'b000100, 0);
        cycle(1, 6'b000100, 1);
        cycle(0, 6'b000000, 1);

        // reset while FULL and stalled
        cycle(1, 6'b001111, 0);
        cycle(1, 6'b001111, 0);
        do_reset();
        cycle(1, 6'b001111, 1);
        cycle(0, 6'b000000, 1);

        // non-power-of-2 wrap on the N=6 instance
        do_reset();
        cycle(1, 6'b100000, 1);
        cycle(1, 6'b100001, 1);
        cycle(0, 6'b000000, 1);

        for (int i = 0; i < 400; i++) begin
            logic [5:0] r;
            r = 6'($urandom);
            if ($urandom_range(0, 5) == 0) r = '0;
            cycle(logic'($urandom_range(0, 3) != 0), r, logic'($urandom_range(0, 9) < 7));
        end

        repeat (4) cycle(0, 6'b000000, 1);
        chk("drain_a", qa.size(), 0);
        chk("drain_b", qb.size(), 0);
        chk("drain_c", qc.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/prio_enc_pipe.md
Name: prio_enc_pipe

Overview:
Parametrised, registered N-to-log2(N) priority encoder with valid/ready handshakes on input and output. It generalises the team's 4-to-2 combinational encoder:
- any width;
- zero-input (no-hit) reporting;
- selectable fixed or round-robin priority;
- one-stage buffered output so back-pressure is honoured.

It sits between request sources (interrupt lines, FIFO-not-empty flags) and the consumers that select one of them.

Parameters:
N, 4, number of request lines (N >= 2)
W, $clog2(N), width of encoded index (derived; do not override)
RR_MODE, 0, 0 = fixed priority (bit 0 highest); 1 = round-robin starting after last granted index

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request vector valid
in_ready  output  1  block accepts in_req this cycle
in_req  input  N  request vector; bit i = line i requesting
out_valid  output  1  encoded result valid
out_ready  input  1  consumer accepts result this cycle
out_idx  output  W  index of selected request
out_hit  output  1  1 = at least one request bit was set
out_onehot  output  N  one-hot of selected line (all-zero when out_hit=0)

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_idx=0, out_hit=0, out_onehot=0, rr_ptr=0, FSM=EMPTY.
- FSM states:
  - EMPTY: no result held.
  - FULL: result held in output register.
- Input handshake:
  - in_ready = (state==EMPTY) || out_ready. Combinational from out_ready; there is no combinational path from in_valid.
  - Input is accepted when in_valid && in_ready.
- Transitions:
  - EMPTY + accept -> FULL.
  - FULL + out_ready + accept -> FULL (new result loaded, back-to-back at 1 result/cycle).
  - FULL + out_ready + no accept -> EMPTY.
  - FULL + !out_ready -> FULL; out_* held stable, in_ready=0.
- Latency: exactly 1 cycle from accept to out_valid.
- Fixed priority (RR_MODE=0): out_idx = lowest set bit index of in_req.
- Round-robin (RR_MODE=1):
  - Search starts at rr_ptr, ascending, wrapping N-1 -> 0.
  - rr_ptr <= (out_idx+1) mod N, updated only when the output handshake completes (out_valid && out_ready) with out_hit=1.
  - Selection uses rr_ptr as it stands at the accept cycle. On a simultaneous output handshake and new accept, the new input sees the updated rr_ptr (bypass of next-pointer value).
- No-hit: in_req all-zero still produces a result with out_hit=0, out_idx=0, out_onehot=0. rr_ptr unchanged.
- Non-power-of-2 N: out_idx never exceeds N-1.
- Reset mid-operation: any held result is discarded, no output handshake completes, rr_ptr returns to 0.

Optional Feature:
- Macro PRIO_ENC_MULTIHOT_ERR_EN.
- Defined:
  - Adds output port out_multi (1 bit). It is registered alongside out_idx and is 1 when the accepted in_req had two or more bits set (classic encoder ambiguity).
  - Reset value 0; held stable under back-pressure like the other out_* outputs.
- Undefined: port and logic absent. All other behaviour identical.

Decomposition:
- Package prio_enc_pkg holds:
  - constant PRIO_FIXED=0, PRIO_RR=1;
  - enum state_t {EMPTY, FULL};
  - function clog2_min1 (returns >=1).
- Natural sub-module: prio_find_first (combinational). Takes vector + start pointer; returns idx, hit, onehot. It is reused by the fixed path (start=0) and the RR path.

Test Plan:
1. N=4, RR_MODE=0, out_ready=1; inputs 0001, 0010, 0100, 1000 back-to-back -> out_idx 0,1,2,3, one per cycle, each 1 cycle after accept, out_hit=1.
2. N=4, RR_MODE=0, in_req=1110 -> out_idx=1, out_onehot=0010. With macro defined: out_multi=1. in_req=0000 -> out_hit=0, out_idx=0.
3. N=4, RR_MODE=1, in_req=1111 repeated 5 times, out_ready=1 -> out_idx 0,1,2,3,0 (wrap). in_req=1001 with rr_ptr=1 -> out_idx=3.
4. Back-pressure: out_ready=0 for 3 cycles after first result -> in_ready=0, out_* stable. Release -> next queued input appears the following cycle; no loss or duplication.
5. Reset mid-operation: assert rst_n=0 while FULL and out_ready=0 -> out_valid drops immediately (async). After release, RR sequence restarts at index 0.
6. N=6 (non-power-of-2), RR_MODE=1, in_req=100000 then 100001 -> out_idx 5, then 0 (rr_ptr wrapped from 6 to 0). out_idx never exceeds 5.
